// File: rtl/instmem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_loader_pkg
//  Description : Shared state encoding, error codes, sync-byte default and
//                a byte-sum helper for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package instmem_loader_pkg;

    // Default frame start marker
    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

    // Error codes reported on the err output
    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_LEN  = 2'd1;
    localparam logic [1:0] c_ERR_CHK  = 2'd2;
    localparam logic [1:0] c_ERR_RDBK = 2'd3;

    // Loader FSM encoding
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_DAT_LO = 4'd3,
        S_DAT_HI = 4'd4,
        S_CHK    = 4'd5,
        S_VERIFY = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    // Modulo-256 sum of the two bytes of a memory word
    function automatic logic [7:0] f_word_sum(input logic [15:0] i_word);
        return i_word[7:0] + i_word[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instmem_verify.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_verify
//  Description : Readback sequencer. Issues N back-to-back reads from word 0
//                and accumulates both bytes of every returned word into an
//                8-bit wrap-around sum. o_done pulses once the sum is final.
//  Revision    : 1.0 - initial release
// ============================================================================
module instmem_verify
    import instmem_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_ceb,
    output logic [ADDR_W-1:0] o_adb,
    output logic              o_done,
    output logic [7:0]        o_sum
);

    localparam logic [ADDR_W:0] c_IDX_ONE = (ADDR_W + 1)'(1);

    logic              r_ceb;
    logic              r_ceb_d;
    logic              r_last_d;
    logic              r_done;
    logic [ADDR_W-1:0] r_adb;
    logic [ADDR_W:0]   r_len;
    logic [7:0]        r_sum;
    logic              w_last;

    // The read currently on the port is the final one of the sequence
    assign w_last = (({1'b0, r_adb} + c_IDX_ONE) == r_len);

    // Read issue, one-cycle-delayed data capture and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ceb    <= 1'b0;
            r_ceb_d  <= 1'b0;
            r_last_d <= 1'b0;
            r_done   <= 1'b0;
            r_adb    <= '0;
            r_len    <= '0;
            r_sum    <= 8'd0;
        end else begin
            r_ceb_d  <= r_ceb;
            r_last_d <= r_ceb & w_last;
            // Sum is complete the cycle after the last data word is captured
            r_done   <= r_last_d;
            if (i_start) begin
                r_ceb <= 1'b1;
                r_adb <= '0;
                r_len <= i_len;
            end else if (r_ceb) begin
                if (w_last) begin
                    r_ceb <= 1'b0;
                end else begin
                    r_adb <= r_adb + 1'b1;
                end
            end
            if (i_start) begin
                r_sum <= 8'd0;
            end else if (r_ceb_d) begin
                r_sum <= r_sum + f_word_sum(i_rd_data);
            end
        end
    end

    assign o_ceb  = r_ceb;
    assign o_adb  = r_adb;
    assign o_done = r_done;
    assign o_sum  = r_sum;

endmodule
`default_nettype wire

// File: rtl/instmem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_loader
//  Description : Receives a framed program image over a byte link, writes it
//                into instruction memory, verifies it by readback and holds
//                the CPU in reset until the image is proven good.
//  Revision    : 1.0 - initial release
// ============================================================================
module instmem_loader
    import instmem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = c_SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_cea,
    output logic [ADDR_W-1:0] mem_ada,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_ceb,
    output logic [ADDR_W-1:0] mem_adb,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [ADDR_W:0] c_IDX_ONE = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rx_ready;
    logic              r_cea;
    logic [ADDR_W-1:0] r_ada;
    logic [DATA_W-1:0] r_din;
    logic [7:0]        r_len_lo;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_widx;
    logic [7:0]        r_lo;
    logic [7:0]        r_sum;
    logic [1:0]        r_err;

    logic              w_acc;
    logic [15:0]       w_len;
    logic              w_len_ovf;
    logic              w_last_word;
    logic              w_restart;
    logic              w_err_set;
    logic [1:0]        w_err_code;
    logic              w_vfy_start;
    logic              w_vfy_done;
    logic [7:0]        w_vfy_sum;

    assign w_acc       = rx_valid & r_rx_ready;
    assign w_len       = {rx_data, r_len_lo};
    assign w_len_ovf   = (32'(w_len) > (32'd1 << ADDR_W));
    assign w_last_word = ((r_widx + c_IDX_ONE) == r_len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-transition control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = c_ERR_NONE;
        w_vfy_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_acc && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = S_LEN_LO;
                    w_restart   = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (w_acc) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_acc) begin
                    if (w_len_ovf) begin
                        w_state_nxt = S_ERR;
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_LEN;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_DAT_LO;
                    end
                end
            end
            S_DAT_LO: begin
                if (w_acc) w_state_nxt = S_DAT_HI;
            end
            S_DAT_HI: begin
                if (w_acc) w_state_nxt = w_last_word ? S_CHK : S_DAT_LO;
            end
            S_CHK: begin
                if (w_acc) begin
                    if (rx_data != r_sum) begin
                        w_state_nxt = S_ERR;
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_CHK;
                    end else if (r_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_VERIFY;
                        w_vfy_start = 1'b1;
                    end
                end
            end
            S_VERIFY: begin
                // r_sum still holds the checksum that was just matched
                if (w_vfy_done) begin
                    if (w_vfy_sum == r_sum) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_RDBK;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte capture, running sum, word writes and error latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready <= 1'b0;
            r_cea      <= 1'b0;
            r_ada      <= '0;
            r_din      <= '0;
            r_len_lo   <= 8'd0;
            r_len      <= '0;
            r_widx     <= '0;
            r_lo       <= 8'd0;
            r_sum      <= 8'd0;
            r_err      <= c_ERR_NONE;
        end else begin
            // Registered from next state so the link stalls exactly in VERIFY
            r_rx_ready <= (w_state_nxt != S_VERIFY);
            r_cea      <= 1'b0;
            if (w_restart) begin
                r_widx <= '0;
                r_sum  <= 8'd0;
                r_err  <= c_ERR_NONE;
            end
            if (w_err_set) begin
                r_err <= w_err_code;
            end
            if (w_acc) begin
                case (r_state)
                    S_LEN_LO: r_len_lo <= rx_data;
                    S_LEN_HI: r_len    <= w_len[ADDR_W:0];
                    S_DAT_LO: begin
                        r_lo  <= rx_data;
                        r_sum <= r_sum + rx_data;
                    end
                    S_DAT_HI: begin
                        r_cea  <= 1'b1;
                        r_ada  <= r_widx[ADDR_W-1:0];
                        r_din  <= {rx_data, r_lo};
                        r_sum  <= r_sum + rx_data;
                        r_widx <= r_widx + c_IDX_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    instmem_verify #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_verify (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_vfy_start),
        .i_len     (r_len),
        .i_rd_data (mem_dout),
        .o_ceb     (mem_ceb),
        .o_adb     (mem_adb),
        .o_done    (w_vfy_done),
        .o_sum     (w_vfy_sum)
    );

    assign rx_ready = r_rx_ready;
    assign mem_cea  = r_cea;
    assign mem_ada  = r_ada;
    assign mem_din  = r_din;
    assign cpu_hold = (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: doc/instmem_loader.md
INSTMEM_LOADER -- requirements
Module: instmem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning memory word width; only 16 is supported.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning load-frame start marker.
REQ-004 clk  input  1  single clock; all ports synchronous to it.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx_data  input  8  byte from host link.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts byte; transfer when rx_valid & rx_ready.
REQ-009 mem_cea  output  1  write-port enable, one cycle per word.
REQ-010 mem_ada  output  ADDR_W  write word address.
REQ-011 mem_din  output  16  write data.
REQ-012 mem_ceb  output  1  read-port enable.
REQ-013 mem_adb  output  ADDR_W  read word address.
REQ-014 mem_dout  input  16  read data, valid one cycle after mem_ceb (bypass mode).
REQ-015 cpu_hold  output  1  holds CPU in reset while loading.
REQ-016 done  output  1  last frame loaded and verified.
REQ-017 err  output  2  0 none, 1 length overflow, 2 checksum mismatch, 3 readback mismatch.

Function
REQ-018 Frame SHALL be: SYNC_BYTE, LEN_LO, LEN_HI (word count N, little-endian), 2N data bytes (low byte first per word), CHK = sum of all data bytes mod 256.
REQ-019 States SHALL be IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHK, VERIFY, DONE, ERR.
REQ-020 IDLE SHALL discard every byte except SYNC_BYTE, which moves to LEN_LO and clears word address, running sum, done, err.
REQ-021 rx_ready SHALL be 1 in IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHK, DONE, ERR; 0 in VERIFY.
REQ-022 On LEN_HI accept: N > 2**ADDR_W -> ERR with err=1; N = 0 -> CHK; else -> DAT_LO.
REQ-023 On DAT_HI accept, mem_cea SHALL pulse high in the next cycle with mem_ada = word index, mem_din = {hi, lo}; no other cycle asserts mem_cea.
REQ-024 Word index SHALL increment after each write; after word N-1 the state SHALL go to CHK.
REQ-025 Running sum SHALL be 8-bit, wrap-around modulo 256, adding every accepted data byte.
REQ-026 On CHK accept: mismatch -> ERR with err=2; match -> VERIFY (N>0) or DONE (N=0).
REQ-027 VERIFY SHALL assert mem_ceb for N consecutive cycles, mem_adb = 0..N-1, and add both bytes of each mem_dout (sampled one cycle after its mem_ceb) into a fresh 8-bit sum.
REQ-028 One cycle after the last read returns: sum equal to CHK -> DONE; else ERR with err=3.
REQ-029 cpu_hold SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE.
REQ-030 In DONE or ERR, an accepted SYNC_BYTE SHALL restart at LEN_LO (err and done cleared); other bytes discarded.
REQ-031 A SYNC_BYTE value inside length/data/checksum fields SHALL be treated as data, not a restart.
REQ-032 Bytes with rx_valid=0 SHALL never change state.

Reset
REQ-033 On rst_n low, immediately: state IDLE, rx_ready=0 until first clock after release, mem_cea=0, mem_ceb=0, mem_ada=0, mem_adb=0, mem_din=0, cpu_hold=1, done=0, err=0, counters and sums 0.
REQ-034 Reset mid-frame SHALL abandon the frame; already-written words are not restored.

Structure
REQ-035 State encoding, err codes and SYNC_BYTE default SHALL live in shared package instmem_loader_pkg.
REQ-036 One sub-module, instmem_verify, SHALL implement the VERIFY read sequencer and readback sum.

Verification
REQ-037 Frame A5 02 00 34 12 78 56 14 -> writes 0x1234@0, 0x5678@1; VERIFY reads 0,1; done=1, cpu_hold=0, err=0.
REQ-038 Frame A5 01 00 11 22 00 (bad CHK) -> one write 0x2211@0; ERR, err=2, done=0, cpu_hold=1.
REQ-039 Frame A5 01 04 (N=1025) -> no mem_cea; ERR, err=1.
REQ-040 Valid 1-word frame with memory model corrupting readback bit 0 -> ERR, err=3.
REQ-041 Garbage 00 FF then A5 00 00 00 -> DONE without writes or reads; then A5 restarts, done drops.
REQ-042 rst_n low during DAT_HI of a 4-word frame -> all outputs at reset values asynchronously; next full frame loads correctly.
